// File: rtl/ccd_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ccd_pkg : shared state encoding and frame-geometry defaults      |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package ccd_pkg;

  localparam int CNT_W          = 13;
  localparam int DUMMY_LEAD_DEF = 64;
  localparam int PIX_ACTIVE_DEF = 5340;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARM     = 3'd1,
    ST_SKIP    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DRAIN   = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/edge_det.sv
`default_nettype none
// +------------------------------------------------------------------+
// | edge_det : falling-edge detector, one registered copy of input   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module edge_det (
  input  logic clk,
  input  logic rst,
  input  logic i_sig,
  output logic o_fall
);

  logic r_prev;

  // Held at 0 through reset so no edge can be reported on the first cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_prev <= 1'b0;
    else     r_prev <= i_sig;
  end

  assign o_fall = r_prev & ~i_sig;

endmodule
`default_nettype wire

// File: rtl/ccd_frame_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ccd_frame_ctrl : CCD line/frame capture sequencer with output reg|
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module ccd_frame_ctrl
  import ccd_pkg::*;
#(
  parameter int ADC_W      = 12,
  parameter int DUMMY_LEAD = DUMMY_LEAD_DEF,
  parameter int PIX_ACTIVE = PIX_ACTIVE_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cont,
  input  logic             abort,
  input  logic             sh,
  input  logic             sp,
  input  logic [ADC_W-1:0] adc_data,
  output logic [ADC_W-1:0] pix_data,
  output logic [CNT_W-1:0] pix_idx,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic             pix_last,
  output logic             busy,
  output logic             frame_done,
  output logic             overrun
);

  localparam logic [CNT_W-1:0] c_DUMMY_END = CNT_W'(DUMMY_LEAD - 1);
  localparam logic [CNT_W-1:0] c_PIX_END   = CNT_W'(PIX_ACTIVE - 1);

  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [ADC_W-1:0] r_pix_data;
  logic [CNT_W-1:0] r_pix_idx;
  logic             r_pix_valid, r_pix_last, r_frame_done, r_overrun, r_last_drop;
  logic             w_sh_fall, w_sp_fall;
  logic             w_accept, w_cap_evt, w_load, w_drop, w_restart, w_done, w_in_frame;

  edge_det u_sh_edge (.clk(clk), .rst(rst), .i_sig(sh), .o_fall(w_sh_fall));
  edge_det u_sp_edge (.clk(clk), .rst(rst), .i_sig(sp), .o_fall(w_sp_fall));

  assign w_in_frame = (r_state == ST_SKIP) || (r_state == ST_CAPTURE);
  assign w_accept   = r_pix_valid && pix_ready;
  assign w_restart  = w_in_frame && w_sh_fall && !abort;
  assign w_cap_evt  = (r_state == ST_CAPTURE) && w_sp_fall && !w_sh_fall && !abort;
  assign w_load     = w_cap_evt && (!r_pix_valid || pix_ready);
  assign w_drop     = w_cap_evt && r_pix_valid && !pix_ready;
  // A dropped last pixel never reaches the output, so DRAIN completes unconditionally.
  assign w_done     = (r_state == ST_DRAIN) && !abort &&
                      (r_last_drop || (w_accept && r_pix_last));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (abort) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:    if (start) w_next = ST_ARM;
        ST_ARM:     if (w_sh_fall) w_next = ST_SKIP;
        ST_SKIP:    if (w_sh_fall) w_next = ST_SKIP;
                    else if (w_sp_fall && r_cnt == c_DUMMY_END) w_next = ST_CAPTURE;
        ST_CAPTURE: if (w_sh_fall) w_next = ST_SKIP;
                    else if (w_sp_fall && r_cnt == c_PIX_END) w_next = ST_DRAIN;
        ST_DRAIN:   if (w_done) w_next = cont ? ST_ARM : ST_IDLE;
        default:    w_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt        <= '0;
      r_pix_data   <= '0;
      r_pix_idx    <= '0;
      r_pix_valid  <= 1'b0;
      r_pix_last   <= 1'b0;
      r_frame_done <= 1'b0;
      r_overrun    <= 1'b0;
      r_last_drop  <= 1'b0;
    end else begin
      r_frame_done <= w_done;
      if (abort) begin
        r_cnt       <= '0;
        r_pix_valid <= 1'b0;
        r_pix_last  <= 1'b0;
        r_last_drop <= 1'b0;
      end else begin
        if (w_sh_fall && (w_in_frame || r_state == ST_ARM))
          r_cnt <= '0;
        else if (w_sp_fall && r_state == ST_SKIP)
          r_cnt <= (r_cnt == c_DUMMY_END) ? '0 : r_cnt + 1'b1;
        else if (w_cap_evt)
          r_cnt <= r_cnt + 1'b1;

        if (w_load) begin
          r_pix_data  <= adc_data;
          r_pix_idx   <= r_cnt;
          r_pix_valid <= 1'b1;
          r_pix_last  <= (r_cnt == c_PIX_END);
        end else if (w_accept) begin
          r_pix_valid <= 1'b0;
        end

        if (w_cap_evt && r_cnt == c_PIX_END)
          r_last_drop <= w_drop;
      end

      if (r_state == ST_IDLE && start && !abort) r_overrun <= 1'b0;
      else if (w_drop || w_restart)              r_overrun <= 1'b1;
    end
  end

  assign pix_data   = r_pix_data;
  assign pix_idx    = r_pix_idx;
  assign pix_valid  = r_pix_valid;
  assign pix_last   = r_pix_last;
  assign busy       = (r_state != ST_IDLE);
  assign frame_done = r_frame_done;
  assign overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_ccd_frame_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_ccd_frame_ctrl : scoreboard bench for ccd_frame_ctrl          |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_ccd_frame_ctrl;

  localparam int ADC_W = 12;
  localparam int DUM   = 6;
  localparam int PIX   = 32;

  typedef struct packed {
    logic [ADC_W-1:0] d;
    logic [12:0]      i;
    logic             l;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst, start, cont, abort, sh, sp, pix_ready;
  logic [ADC_W-1:0] adc_data;
  logic [ADC_W-1:0] pix_data;
  logic [12:0]      pix_idx;
  logic             pix_valid, pix_last, busy, frame_done, overrun;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_done   = 0;
  int   exp_done = 0;
  bit   exp_ovr  = 1'b0;

  ccd_frame_ctrl #(.ADC_W(ADC_W), .DUMMY_LEAD(DUM), .PIX_ACTIVE(PIX)) dut (
    .clk(clk), .rst(rst), .start(start), .cont(cont), .abort(abort),
    .sh(sh), .sp(sp), .adc_data(adc_data),
    .pix_data(pix_data), .pix_idx(pix_idx), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .pix_last(pix_last), .busy(busy),
    .frame_done(frame_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
  endtask

  // Monitor: every handshake observed must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (pix_valid && pix_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pixel", {19'd0, pix_idx}, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("pix_data", pix_data, e.d);
          check("pix_idx",  pix_idx,  e.i);
          check("pix_last", pix_last, e.l);
        end
      end
      if (frame_done) n_done++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sp_cycle(input logic [ADC_W-1:0] v, input bit rdy);
    sp = 1'b1; pix_ready = rdy;
    tick(); tick();
    sp = 1'b0; adc_data = v;
    tick(); tick();
  endtask

  task automatic sh_pulse();
    pix_ready = 1'b1;
    sh = 1'b1; tick(); tick();
    sh = 1'b0; tick(); tick();
  endtask

  task automatic do_start();
    pix_ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    exp_ovr = 1'b0;
    check("busy_after_start", busy, 1);
  endtask

  // rmode: 0 always ready, 1 random, 2 last two pixels not ready, 3 random with pixels 5..7 not ready
  task automatic run_frame(input int npix, input bit noise, input bit restart, input int rmode);
    bit rp, r, drop;
    logic [ADC_W-1:0] v;
    if (noise) repeat (3) sp_cycle(ADC_W'($urandom), 1'b1);
    sh_pulse();
    if (restart) exp_ovr = 1'b1;
    for (int j = 0; j < DUM; j++) sp_cycle(ADC_W'($urandom), 1'b1);
    rp = 1'b1;
    for (int k = 0; k < npix; k++) begin
      case (rmode)
        1:       r = ($urandom_range(0, 3) != 0);
        2:       r = (k < PIX - 2);
        3:       r = (k >= 5 && k <= 7) ? 1'b0 : ($urandom_range(0, 3) != 0);
        default: r = 1'b1;
      endcase
      v = ADC_W'($urandom);
      // A pixel is lost only if its predecessor's period and its own period both saw ready low.
      drop = (k > 0) && !rp && !r;
      if (drop) exp_ovr = 1'b1;
      else      exp_q.push_back('{d: v, i: 13'(k), l: (k == PIX - 1)});
      sp_cycle(v, r);
      rp = r;
    end
    if (npix == PIX) begin
      pix_ready = 1'b1;
      repeat (4) tick();
      exp_done++;
    end
  endtask

  task automatic end_of_frame_checks(input string tag, input bit exp_busy);
    check({tag, "_done_count"}, n_done, exp_done);
    check({tag, "_busy"}, busy, exp_busy);
    check({tag, "_overrun"}, overrun, exp_ovr);
    check({tag, "_queue_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    logic [ADC_W-1:0] v;
    rst = 1'b1; start = 1'b0; cont = 1'b0; abort = 1'b0;
    sh = 1'b0; sp = 1'b0; pix_ready = 1'b1; adc_data = '0;
    repeat (3) tick();
    check("rst_pix_valid",  pix_valid,  0);
    check("rst_busy",       busy,       0);
    check("rst_overrun",    overrun,    0);
    check("rst_frame_done", frame_done, 0);
    check("rst_pix_idx",    pix_idx,    0);
    check("rst_pix_data",   pix_data,   0);
    rst = 1'b0;
    tick();

    // Single frame, always ready, with sp activity ignored while armed.
    do_start();
    run_frame(PIX, 1'b1, 1'b0, 0);
    end_of_frame_checks("single", 1'b0);

    // Backpressure window forces drops; surviving indices must stay in order.
    do_start();
    run_frame(PIX, 1'b0, 1'b0, 3);
    end_of_frame_checks("backpressure", 1'b0);

    // Final pixel dropped: frame still completes.
    do_start();
    run_frame(PIX, 1'b0, 1'b0, 2);
    end_of_frame_checks("last_dropped", 1'b0);

    // Continuous mode: re-arms after the first frame, ignores sp before next sh.
    cont = 1'b1;
    do_start();
    run_frame(PIX, 1'b0, 1'b0, 1);
    end_of_frame_checks("cont_first", 1'b1);
    cont = 1'b0;
    run_frame(PIX, 1'b1, 1'b0, 0);
    end_of_frame_checks("cont_second", 1'b0);

    // Extra sh fall mid-capture restarts the frame and flags overrun.
    do_start();
    run_frame(10, 1'b0, 1'b0, 0);
    run_frame(PIX, 1'b0, 1'b1, 0);
    end_of_frame_checks("restart", 1'b0);

    // Abort (with a competing start) while a pixel is held.
    do_start();
    run_frame(10, 1'b0, 1'b0, 0);
    v = ADC_W'($urandom);
    exp_q.push_back('{d: v, i: 13'd10, l: 1'b0});
    sp_cycle(v, 1'b0);
    check("abort_pre_valid", pix_valid, 1);
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    void'(exp_q.pop_back());
    check("abort_pix_valid", pix_valid, 0);
    check("abort_busy", busy, 0);
    pix_ready = 1'b1;
    repeat (4) tick();
    check("abort_no_done", n_done, exp_done);
    check("abort_queue_empty", exp_q.size(), 0);

    // Asynchronous reset in the middle of capture, then a full frame.
    do_start();
    run_frame(5, 1'b0, 1'b0, 1);
    v = ADC_W'($urandom);
    sp_cycle(v, 1'b0);
    #2 rst = 1'b1;
    #1;
    exp_q.delete();
    exp_ovr = 1'b0;
    check("arst_pix_valid", pix_valid, 0);
    check("arst_pix_data",  pix_data,  0);
    check("arst_pix_idx",   pix_idx,   0);
    check("arst_pix_last",  pix_last,  0);
    check("arst_busy",      busy,      0);
    check("arst_overrun",   overrun,   0);
    tick();
    rst = 1'b0;
    pix_ready = 1'b1;
    tick();
    do_start();
    run_frame(PIX, 1'b0, 1'b0, 1);
    end_of_frame_checks("after_reset", 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ccd_frame_ctrl.md
CCD_FRAME_CTRL -- requirements
Module: ccd_frame_ctrl

Interface
REQ-001 SHALL have parameter ADC_W, default 12, meaning ADC sample width in bits.
REQ-002 SHALL have parameter DUMMY_LEAD, default 64, meaning leading dummy pixels discarded per frame.
REQ-003 SHALL have parameter PIX_ACTIVE, default 5340, meaning active pixels delivered per frame.
REQ-004 clk  input  1  system clock; single clock domain.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 start  input  1  one-cycle request to capture a frame.
REQ-007 cont  input  1  continuous mode: re-arm after each frame while high.
REQ-008 abort  input  1  one-cycle request to return to IDLE.
REQ-009 sh  input  1  sensor-driver shift gate, synchronous to clk.
REQ-010 sp  input  1  sensor-driver sample pulse, synchronous to clk.
REQ-011 adc_data  input  ADC_W  ADC conversion result.
REQ-012 pix_data  output  ADC_W  captured pixel value.
REQ-013 pix_idx  output  13  active-pixel index 0..PIX_ACTIVE-1.
REQ-014 pix_valid  output  1  pix_data/pix_idx valid.
REQ-015 pix_ready  input  1  downstream accepts when high with pix_valid.
REQ-016 pix_last  output  1  qualifies the final pixel of a frame.
REQ-017 busy  output  1  high in any state other than IDLE.
REQ-018 frame_done  output  1  one-cycle pulse after the last pixel is accepted.
REQ-019 overrun  output  1  sticky: a pixel was dropped.

Function
REQ-020 SHALL implement states IDLE, ARM, SKIP, CAPTURE, DRAIN.
REQ-021 SHALL detect sh falling edge and sp falling edge with a one-cycle registered copy; no other edge qualifies.
REQ-022 IDLE -> ARM on start; start while busy is ignored.
REQ-023 ARM -> SKIP on sh falling edge; sp edges in ARM are ignored.
REQ-024 SKIP: count sp falling edges; -> CAPTURE after DUMMY_LEAD edges, no data output.
REQ-025 CAPTURE: on each sp falling edge, register adc_data into the output register with pix_idx = running count, the same cycle the edge is detected (latency 1 clk after sp falls).
REQ-026 Output register: pix_valid set on capture, cleared on pix_valid&&pix_ready with no simultaneous capture; a simultaneous accept and capture loads the new pixel with pix_valid held high.
REQ-027 Capture while pix_valid&&!pix_ready: new pixel dropped, held pixel unchanged, overrun set; pixel count still advances.
REQ-028 After capture of index PIX_ACTIVE-1 (pix_last=1) -> DRAIN.
REQ-029 DRAIN: on acceptance of the last pixel, pulse frame_done; -> ARM if cont=1, else IDLE.
REQ-030 If the last pixel was dropped, frame_done SHALL pulse on entry to DRAIN+1 cycle instead.
REQ-031 sh falling edge during SKIP or CAPTURE: frame restarts in SKIP, counters cleared, overrun set.
REQ-032 abort in any state: -> IDLE next cycle, pix_valid cleared, counters cleared; abort takes priority over start.
REQ-033 Counters SHALL be 13 bits, compared for equality, never wrap within a frame.
REQ-034 overrun cleared only by rst or start accepted in IDLE.

Reset
REQ-035 rst SHALL force IDLE, pix_data=0, pix_idx=0, pix_valid=0, pix_last=0, busy=0, frame_done=0, overrun=0, edge registers=0, asynchronously.
REQ-036 Deassertion of rst SHALL require no sh edge to be seen on the first cycle (edge registers held 0).

Structure
REQ-037 State encoding and default DUMMY_LEAD/PIX_ACTIVE constants SHALL reside in shared package ccd_pkg.
REQ-038 Edge detection SHALL be one sub-module, edge_det, instantiated for sh and sp.

Verification
REQ-039 start, cont=0, pix_ready=1, drive sh/sp like the sensor driver -> 5340 pixels, idx 0..5339, first pixel = adc at 65th sp fall, one frame_done, busy low after.
REQ-040 pix_ready=0 for 3 sp periods in CAPTURE -> overrun=1, held pixel unchanged, later indices contiguous with skipped values absent.
REQ-041 cont=1, two frames -> frame_done twice, ARM between frames, no pixels from sp edges before second sh fall.
REQ-042 abort at pixel 100 -> IDLE next cycle, pix_valid=0, busy=0, no frame_done.
REQ-043 extra sh falling edge at pixel 2000 -> overrun=1, idx restarts at 0 after 64 dummies.
REQ-044 rst asserted mid-CAPTURE asynchronously -> all outputs 0 immediately; start after release captures full frame.
